alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU (operands a/b, 3-bit alu_sel, result, ZERO flag) between two requesters, e.g. the execute stage and the branch-compare/address unit.
- Round-robin arbitration, registered operand issue, registered result capture, and a per-requester valid/ready response channel.
- Sits between the requesters and the existing ALU instance; the ALU itself stays purely combinational.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- SEL_W, 3, ALU op-select width; passed through unmodified.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a  in  WIDTH  requester 0 operand a
- req0_b  in  WIDTH  requester 0 operand b
- req0_op  in  SEL_W  requester 0 ALU select
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
- alu_a  out  WIDTH  to ALU operand a
- alu_b  out  WIDTH  to ALU operand b
- alu_sel  out  SEL_W  to ALU select
- alu_res  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU ZERO flag
- rsp0_valid  out  1  result ready for requester 0
- rsp0_ready  in  1  requester 0 takes the result
- rsp0_res  out  WIDTH  captured result
- rsp0_zero  out  1  captured ZERO flag
- rsp1_valid / rsp1_ready / rsp1_res / rsp1_zero  same as requester 0, for requester 1

Behaviour:
- **Reset (async, rst=1):**
  - state=IDLE; rr_ptr=0 (requester 0 has priority).
  - Operand registers, alu_a, alu_b, alu_sel = 0.
  - Result register and rspN_res, rspN_zero = 0.
  - rspN_valid=0; reqN_ready=0.
  - Reset asserted mid-operation aborts the op and discards any result. No response is produced.
- **State machine:** IDLE -> EXEC -> RESP -> IDLE.
- **IDLE:**
  - reqN_ready is combinational and goes high for the granted requester only.
  - Grant rules:
    - Only req0_valid=1: grant 0.
    - Only req1_valid=1: grant 1.
    - Both valid: grant rr_ptr.
  - On the accepting edge: latch a, b, op and the grant id (gid) into operand registers, then go to EXEC.
  - No valid requests: stay in IDLE with both readies low.
- **EXEC:**
  - alu_a, alu_b, alu_sel are driven from the operand registers. These registers are the outputs; there is no combinational path from req inputs to the ALU.
  - At the end of the cycle, capture alu_res and alu_zero into the result register and go to RESP.
- **RESP:**
  - rsp[gid]_valid=1; the other rsp_valid stays 0.
  - rspN_res/zero present the result register. The result is held stable while valid and not ready.
  - On rsp[gid]_ready=1: rr_ptr <= ~gid, drop valid, go to IDLE.
  - rsp_ready from the non-granted requester is ignored.
- **Timing:**
  - Accept edge at cycle N; rsp valid is visible in cycle N+2.
  - Best-case throughput is one op per 3 cycles.
  - reqN_ready is low in EXEC and RESP.
- **Fairness:** under continuous dual requests, grants strictly alternate 0,1,0,1. A requester never waits more than one foreign op.
- **Idle hold:** the operand registers keep the last issued op, so ALU outputs do not toggle while idle.
- **rspN_res/zero outputs:** driven from the shared result register regardless of valid. Consumers qualify them with rspN_valid.
- **Widths:** WIDTH-bit values are passed verbatim; there is no arithmetic inside the block, and ZERO is taken from the ALU only.

Test Plan:
- **Reset state:** assert rst mid-EXEC (req0 op a=0x30, b=0x3e accepted the cycle before) -> all outputs 0 immediately, state IDLE; no rsp0_valid after release.
- **Single requester:** req0 a=0x30, b=0x3e, op=3'b000, rsp0_ready=1 ->
  - req0_ready high in cycle N;
  - alu_a=0x30, alu_b=0x3e, alu_sel=0 in N+1;
  - rsp0_valid in N+2 with rsp0_res equal to the ALU output for op 0, and rsp0_zero matching;
  - rsp1_valid stays 0.
- **Sweep:** req1 issues ops 0..7 with a=0x30, b=0x3e -> each rsp1_res/rsp1_zero equals the ALU's direct output for that op; ops return in issue order.
- **Contention:** both valid continuously from reset, rsp ready=1 ->
  - grant order 0,1,0,1;
  - exactly one reqN_ready per 3-cycle op.
- **Backpressure:** hold rsp0_ready=0 for 5 cycles ->
  - rsp0_valid, res and zero are held stable;
  - req1_ready stays 0 throughout;
  - after ready, next grant goes to req1.
- **Zero flag:** op with a=b=0x0000_0005 on a subtract-type op -> rsp_zero=1; a=0x30, b=0x3e -> rsp_zero=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands and results are registered; each requester gets its own valid/ready response.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_res,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_res,
  output logic             rsp1_zero,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // reqN_ready is only ever high in IDLE; rspN_valid is only ever high in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             gid_q, gid_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [SEL_W-1:0] op_sel_q, op_sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;

  logic any_req;
  logic grant;
  logic rsp_fire;

  assign any_req  = req0_valid | req1_valid;
  // With a single requester it wins outright; with both, the pointer decides.
  assign grant    = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
  assign rsp_fire = gid_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gid_d      = gid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    res_d      = res_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req0_ready = ~grant;
          req1_ready = grant;
          gid_d      = grant;
          op_a_d     = grant ? req1_a  : req0_a;
          op_b_d     = grant ? req1_b  : req0_b;
          op_sel_d   = grant ? req1_op : req0_op;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~gid_q;
        rsp1_valid = gid_q;
        if (rsp_fire) begin
          rr_ptr_d = ~gid_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      gid_q    <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_sel_q <= op_sel_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
    end
  end

  // Operand registers feed the ALU directly so it stays quiet while idle.
  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_sel   = op_sel_q;
  assign rsp0_res  = res_q;
  assign rsp0_zero = zero_q;
  assign rsp1_res  = res_q;
  assign rsp1_zero = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a reference ALU model, directed driver tasks and a
// response scoreboard fed in issue order.
module tb_alu_arbiter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]    req0_op = '0, req1_op = '0;
  logic [W-1:0]  alu_a, alu_b, alu_res;
  logic [2:0]    alu_sel;
  logic          alu_zero;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0]  rsp0_res, rsp1_res;
  logic          rsp0_zero, rsp1_zero;
  logic [1:0]    dbg_state;

  // {gid, result, zero}
  logic [W+1:0]  exp_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  alu_arbiter #(.WIDTH(W), .SEL_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_res(rsp0_res), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_res(rsp1_res), .rsp1_zero(rsp1_zero),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      3'd0: alu_res = alu_a + alu_b;
      3'd1: alu_res = alu_a - alu_b;
      3'd2: alu_res = alu_a & alu_b;
      3'd3: alu_res = alu_a | alu_b;
      3'd4: alu_res = alu_a ^ alu_b;
      3'd5: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      3'd6: alu_res = alu_a << alu_b[4:0];
      default: alu_res = ~(alu_a | alu_b);
    endcase
  end
  assign alu_zero = (alu_res == '0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops on every response handshake
  always @(negedge clk) begin
    if (!rst) begin
      check("rsp_onehot", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
      if (rsp0_valid && rsp0_ready) begin
        if (exp_q.size() == 0) check("rsp0_unexpected", 64'd1, 64'd0);
        else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          check("rsp0_gid",  {63'd0, 1'b0}, {63'd0, e[W+1]});
          check("rsp0_res",  {32'd0, rsp0_res}, {32'd0, e[W:1]});
          check("rsp0_zero", {63'd0, rsp0_zero}, {63'd0, e[0]});
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp_q.size() == 0) check("rsp1_unexpected", 64'd1, 64'd0);
        else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          check("rsp1_gid",  {63'd0, 1'b1}, {63'd0, e[W+1]});
          check("rsp1_res",  {32'd0, rsp1_res}, {32'd0, e[W:1]});
          check("rsp1_zero", {63'd0, rsp1_zero}, {63'd0, e[0]});
        end
      end
    end
  end

  // Driver: present one op, wait for its grant, drop valid after the accept edge
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic [W-1:0] er, input logic ez);
    logic rdy;
    exp_q.push_back({id[0], er, ez});
    if (id == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    else         begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    #1;
    rdy = (id == 0) ? req0_ready : req1_ready;
    for (int i = 0; i < 20 && !rdy; i++) begin
      tick();
      rdy = (id == 0) ? req0_ready : req1_ready;
    end
    check("issue_ready", {63'd0, rdy}, 64'd1);
    tick();
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int id);
    logic v;
    v = (id == 0) ? rsp0_valid : rsp1_valid;
    for (int i = 0; i < 20 && !v; i++) begin
      tick();
      v = (id == 0) ? rsp0_valid : rsp1_valid;
    end
    check("rsp_arrives", {63'd0, v}, 64'd1);
    tick();
  endtask

  logic [W-1:0] sweep_res [8] = '{32'h6E, 32'hFFFF_FFF2, 32'h30, 32'h3E,
                                  32'h0E, 32'h1, 32'h0, 32'hFFFF_FFC1};
  logic         sweep_zero[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int grants;

    // Reset asserted mid-EXEC
    tick(); tick();
    rst = 1'b0;
    tick();
    req0_a = 32'h30; req0_b = 32'h3e; req0_op = 3'd0; req0_valid = 1'b1;
    #1;
    check("abort_accept", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    check("abort_in_exec", {62'd0, dbg_state}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_state",  {62'd0, dbg_state}, 64'd0);
    check("rst_alu_a",  {32'd0, alu_a}, 64'd0);
    check("rst_alu_b",  {32'd0, alu_b}, 64'd0);
    check("rst_alu_sel", {61'd0, alu_sel}, 64'd0);
    check("rst_rsp_res", {rsp0_res, rsp1_res}, 64'd0);
    check("rst_flags", {58'd0, rsp0_zero, rsp1_zero, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("abort_no_rsp", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
      tick();
    end

    // Single requester with cycle-exact timing
    req0_a = 32'h30; req0_b = 32'h3e; req0_op = 3'd0; req0_valid = 1'b1;
    exp_q.push_back({1'b0, 32'h6E, 1'b0});
    #1;
    check("single_ready0_N", {63'd0, req0_ready}, 64'd1);
    check("single_ready1_N", {63'd0, req1_ready}, 64'd0);
    tick();
    req0_valid = 1'b0;
    check("single_alu_a",   {32'd0, alu_a}, 64'h30);
    check("single_alu_b",   {32'd0, alu_b}, 64'h3e);
    check("single_alu_sel", {61'd0, alu_sel}, 64'd0);
    check("single_busy_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    check("single_no_rsp_N1", {63'd0, rsp0_valid}, 64'd0);
    tick();
    check("single_rsp0_N2", {63'd0, rsp0_valid}, 64'd1);
    check("single_rsp1_N2", {63'd0, rsp1_valid}, 64'd0);
    check("single_res_N2",  {32'd0, rsp0_res}, 64'h6E);
    tick();

    // Sweep every op from requester 1
    for (int op = 0; op < 8; op++) begin
      issue(1, 32'h30, 32'h3e, op[2:0], sweep_res[op], sweep_zero[op]);
      wait_rsp(1);
    end

    // Contention from a fresh reset: grants must alternate
    rst = 1'b1; tick(); rst = 1'b0;
    req0_a = 32'h5;  req0_b = 32'h5;  req0_op = 3'd1;
    req1_a = 32'h30; req1_b = 32'h3e; req1_op = 3'd4;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back({1'b0, 32'h0, 1'b1});
      else            exp_q.push_back({1'b1, 32'h0E, 1'b0});
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    grants = 0;
    #1;
    for (int i = 0; i < 12; i++) begin
      check("cont_not_both", {63'd0, req0_ready & req1_ready}, 64'd0);
      if (req0_ready || req1_ready) begin
        check("cont_grant_order", {63'd0, req1_ready}, {63'd0, grants[0]});
        grants++;
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_grant_count", 64'(grants), 64'd4);
    tick();

    // Backpressure on requester 0 while requester 1 waits
    rsp0_ready = 1'b0;
    req1_a = 32'h7; req1_b = 32'h7; req1_op = 3'd1;
    req1_valid = 1'b1;
    issue(0, 32'h30, 32'h3e, 3'd1, 32'hFFFF_FFF2, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  {63'd0, rsp0_valid}, 64'd1);
      check("bp_res",    {32'd0, rsp0_res}, 64'hFFFF_FFF2);
      check("bp_zero",   {63'd0, rsp0_zero}, 64'd0);
      check("bp_ready1", {63'd0, req1_ready}, 64'd0);
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    req0_valid = 1'b1;
    exp_q.push_back({1'b1, 32'h0, 1'b1});
    #1;
    check("bp_next_grant1", {62'd0, req0_ready, req1_ready}, 64'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(1);

    tick(); tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
